// File: rtl/pu_load_sequencer.sv
// Operand/result storage sequencer for the PU: gathers four operand words,
// pulses the operand-memory load, waits out the PU latency, then stores the result.
//
// state | meaning
// FILL  | accepting operand words into x1..x4
// LOAD  | ld_en pulse, operand memory captures x1..x4
// COMP  | waiting PU_LAT cycles for the PU result
// STORE | res_en pulse, result memory captures PU output
// DONE  | out_valid held until the consumer acknowledges
module pu_load_sequencer #(
    parameter int WIDTH  = 32,
    parameter int PU_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] x1,
    output logic [WIDTH-1:0] x2,
    output logic [WIDTH-1:0] x3,
    output logic [WIDTH-1:0] x4,
    output logic             ld_en,
    output logic             res_en,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      frames
);

    typedef enum logic [2:0] {
        FILL  = 3'd0,
        LOAD  = 3'd1,
        COMP  = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(PU_LAT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       idx;
    logic [7:0]       cnt;
    logic [WIDTH-1:0] x_q [4];
    logic [15:0]      frames_q;
    logic             accept;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (accept && idx == 2'd3) state_nxt = LOAD;
            LOAD:    state_nxt = COMP;
            COMP:    if (cnt == CNT_LAST) state_nxt = STORE;
            STORE:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= 2'd0;
            cnt      <= 8'd0;
            frames_q <= 16'd0;
            for (int i = 0; i < 4; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                x_q[idx] <= in_data;
                idx      <= idx + 2'd1;
            end
            if (state == LOAD) begin
                cnt <= 8'd0;
            end else if (state == COMP) begin
                cnt <= cnt + 8'd1;
            end
            if (state == DONE && out_ready) begin
                frames_q <= frames_q + 16'd1;
            end
        end
    end

    // Controls are masked while rst is high since reset only lands at the next edge.
    always_comb begin
        in_ready  = 1'b0;
        ld_en     = 1'b0;
        res_en    = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        if (!rst) begin
            busy = (state != FILL);
            case (state)
                FILL:    in_ready  = 1'b1;
                LOAD:    ld_en     = 1'b1;
                STORE:   res_en    = 1'b1;
                DONE:    out_valid = 1'b1;
                default: ;
            endcase
        end
    end

    assign x1     = x_q[0];
    assign x2     = x_q[1];
    assign x3     = x_q[2];
    assign x4     = x_q[3];
    assign frames = frames_q;

endmodule

// File: doc/pu_load_sequencer.md
# pu_load_sequencer

Sequencer for the processing-unit operand/result storage. It gathers four 32-bit operands from an upstream valid/ready stream and stages them. It then pulses the load enable of the four-word operand memory, waits a fixed PU compute latency, and pulses the enable of the one-word result memory. Finally it raises a completion handshake toward the downstream consumer. It sits between the input stream and the PU datapath and owns all enables of both memories.

## Interface

- `WIDTH`, 32: operand word width.
- `PU_LAT`, 3: PU compute latency in cycles. Legal range is 1..255.
- `clk`  in  1: clock. All state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_data`  in  WIDTH: operand word.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: sequencer accepts a word this cycle.
- `x1`, `x2`, `x3`, `x4`  out  WIDTH each: staged operands, wired to the operand memory inputs.
- `ld_en`  out  1: operand-memory write enable, one-cycle pulse.
- `res_en`  out  1: result-memory write enable, one-cycle pulse.
- `busy`  out  1: high in every state except FILL.
- `out_valid`  out  1: result stored, waiting for the consumer.
- `out_ready`  in  1: consumer acknowledges.
- `frames`  out  16: count of completed frames.

## Operation

- FSM states are FILL, LOAD, COMP, STORE and DONE.
- **FILL**
  - `in_ready` = 1.
  - A word is accepted when `in_valid` && `in_ready`. It is written to `x[idx]` and the 2-bit `idx` increments (order `x1`, `x2`, `x3`, `x4`).
  - The accept at `idx`=3 wraps `idx` to 0 and moves the FSM to LOAD.
  - Cycles with `in_valid`=0 change nothing.
- **LOAD**
  - `ld_en` = 1 for exactly one cycle, then COMP.
  - The counter is cleared to 0.
- **COMP**
  - Lasts exactly `PU_LAT` cycles; the counter increments each cycle.
  - Leaves when counter = `PU_LAT`-1, then STORE.
- **STORE**
  - `res_en` = 1 for exactly one cycle, then DONE.
- **DONE**
  - `out_valid` = 1, held until `out_ready`=1.
  - On the handshake cycle: go to FILL, `frames` increments, and `out_valid` drops the next cycle.
  - `frames` wraps from 0xFFFF to 0x0000.
- `x1`..`x4` change only in FILL, so they are stable from LOAD through DONE.
- `in_ready` = 0 in every state other than FILL. Input words offered then are neither consumed nor corrupt the staged operands.
- `ld_en`, `res_en` and `out_valid` are mutually exclusive and decoded from state.
- **Reset** (`rst`=1 at an edge, in any state, including mid-COMP or mid-DONE):
  - State goes to FILL; `idx`, the counter, `x1`..`x4` and `frames` go to 0.
  - While `rst` is high: `in_ready`=0, `ld_en`=0, `res_en`=0, `out_valid`=0, `busy`=0.
  - A partially filled frame is discarded.
- Reset values of all outputs: `in_ready` 0 while `rst` is high and 1 on the first cycle after it drops. Every other output is 0.

## Timing

- Let the fourth word be accepted at edge T.
  - `ld_en` is high in cycle T+1.
  - COMP occupies cycles T+2 .. T+1+`PU_LAT`.
  - `res_en` is high in cycle T+2+`PU_LAT`.
  - `out_valid` is first high in cycle T+3+`PU_LAT`.
- If `out_ready` is already 1, DONE lasts one cycle and `in_ready` is 1 the following cycle.
- Minimum frame period: 4 (fill) + 1 + `PU_LAT` + 1 + 1 cycles. That is 10 cycles at `PU_LAT`=3.
- The operand memory captures `x1`..`x4` at the edge ending the `ld_en` cycle.
- The result memory captures the PU output at the edge ending the `res_en` cycle. The PU must present its result `PU_LAT` cycles after operand load.
- No combinational path from `in_valid` or `out_ready` to any output. All outputs are decoded from registered state.

## Test plan

- **Basic frame:** reset, then stream 0x11, 0x22, 0x33, 0x44 with `in_valid`=1 and `out_ready`=1, `PU_LAT`=3.
  - `x1`..`x4` = 0x11..0x44.
  - `ld_en` one cycle after the fourth accept, `res_en` 4 cycles later.
  - `out_valid` for one cycle, `frames`=1.
- **Gapped input:** drive `in_valid` 1,0,0,1,1,0,1.
  - Exactly four words accepted, in order, with no duplicates.
  - `ld_en` asserts once, after the fourth accept.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in DONE while offering 0xAA.
  - `out_valid` held high for 5 cycles, `in_ready`=0 throughout.
  - `x4` unchanged.
  - After `out_ready`=1, one handshake occurs and `frames` increments once.
- **Reset mid-COMP:** assert `rst` during the second COMP cycle.
  - `res_en` never pulses and `frames` stays 0.
  - Next frame 0x5, 0x6, 0x7, 0x8 yields `x1`=0x5 with normal timing.
- **`PU_LAT`=1 and wrap:** with `PU_LAT`=1, `res_en` is exactly 2 cycles after `ld_en`. Preload `frames` via 65536 back-to-back frames (or force it); the count goes 0xFFFF→0x0000.
